decode_execute_pipe_reg: RTL and testbench

- Parametrised decode→execute pipeline register; next generation of the fixed 12/32/5-bit D/X latch.
- Adds stall (hold), flush (bubble insertion), a valid bit, a packed control-enable vector, and writeback capture into held operands during a stall.
- Includes a saturating stall-cycle counter for performance visibility.
- Sits between the decode stage (regfile read) and the execute stage (ALU/branch/RAM).

---
 rtl/decode_execute_pipe_reg.sv | 120 ++++++++++++
 tb/tb_decode_execute_pipe_reg.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_pipe_reg.sv
// Decode-to-execute pipeline register with stall hold, flush bubbles, writeback
// capture into held operands, and a saturating stall-cycle counter.
module decode_execute_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 12,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 7,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               d_valid,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [DATA_W-1:0]  d_instruction,
  input  logic [RADDR_W-1:0] d_rs_addr,
  input  logic [RADDR_W-1:0] d_rt_addr,
  input  logic [DATA_W-1:0]  d_operand_a,
  input  logic [DATA_W-1:0]  d_operand_b,
  input  logic [RADDR_W-1:0] d_wr_addr,
  input  logic [CTRL_W-1:0]  d_ctrl,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               x_valid,
  output logic [PC_W-1:0]    x_pc,
  output logic [DATA_W-1:0]  x_instruction,
  output logic [RADDR_W-1:0] x_rs_addr,
  output logic [RADDR_W-1:0] x_rt_addr,
  output logic [DATA_W-1:0]  x_operand_a,
  output logic [DATA_W-1:0]  x_operand_b,
  output logic [RADDR_W-1:0] x_wr_addr,
  output logic [CTRL_W-1:0]  x_ctrl,
  output logic [CNT_W-1:0]   stall_count
);

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_STALL = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mode_t mode;
  logic  wb_live;
  logic  wb_hit_a;
  logic  wb_hit_b;

  always_comb begin
    mode = MODE_LOAD;
    if (flush)
      mode = MODE_FLUSH;
    else if (stall)
      mode = MODE_STALL;
  end

  // Register 0 is hardwired, and a bubble has no live operands to refresh.
  assign wb_live  = wb_en && (wb_addr != '0) && x_valid;
  assign wb_hit_a = wb_live && (wb_addr == x_rs_addr);
  assign wb_hit_b = wb_live && (wb_addr == x_rt_addr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_valid       <= 1'b0;
      x_pc          <= '0;
      x_instruction <= '0;
      x_rs_addr     <= '0;
      x_rt_addr     <= '0;
      x_operand_a   <= '0;
      x_operand_b   <= '0;
      x_wr_addr     <= '0;
      x_ctrl        <= '0;
    end else begin
      case (mode)
        MODE_LOAD: begin
          x_valid       <= d_valid;
          x_pc          <= d_pc;
          x_instruction <= d_instruction;
          x_rs_addr     <= d_rs_addr;
          x_rt_addr     <= d_rt_addr;
          x_operand_a   <= d_operand_a;
          x_operand_b   <= d_operand_b;
          x_wr_addr     <= d_wr_addr;
          x_ctrl        <= d_ctrl;
        end
        MODE_FLUSH: begin
          // PC and source addresses still track decode for debug visibility.
          x_valid       <= 1'b0;
          x_pc          <= d_pc;
          x_instruction <= '0;
          x_rs_addr     <= d_rs_addr;
          x_rt_addr     <= d_rt_addr;
          x_operand_a   <= '0;
          x_operand_b   <= '0;
          x_wr_addr     <= '0;
          x_ctrl        <= '0;
        end
        MODE_STALL: begin
          if (wb_hit_a)
            x_operand_a <= wb_data;
          if (wb_hit_b)
            x_operand_b <= wb_data;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if ((mode == MODE_STALL) && (stall_count != CNT_MAX))
      stall_count <= stall_count + CNT_ONE;
  end

endmodule

// File: tb/tb_decode_execute_pipe_reg.sv
// Scoreboard bench for decode_execute_pipe_reg: directed vectors push expected
// stage contents; monitors pop and compare after each edge or async event.
module tb_decode_execute_pipe_reg;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        d_valid = 1'b0;
  logic [11:0] d_pc = '0;
  logic [31:0] d_instruction = '0;
  logic [4:0]  d_rs_addr = '0;
  logic [4:0]  d_rt_addr = '0;
  logic [31:0] d_operand_a = '0;
  logic [31:0] d_operand_b = '0;
  logic [4:0]  d_wr_addr = '0;
  logic [6:0]  d_ctrl = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic        x_valid;
  logic [11:0] x_pc;
  logic [31:0] x_instruction;
  logic [4:0]  x_rs_addr, x_rt_addr, x_wr_addr;
  logic [31:0] x_operand_a, x_operand_b;
  logic [6:0]  x_ctrl;
  logic [15:0] stall_count;

  logic        s_valid;
  logic [11:0] s_pc;
  logic [31:0] s_instruction;
  logic [4:0]  s_rs_addr, s_rt_addr, s_wr_addr;
  logic [31:0] s_operand_a, s_operand_b;
  logic [6:0]  s_ctrl;
  logic [3:0]  s_stall_count;

  decode_execute_pipe_reg dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .d_valid(d_valid), .d_pc(d_pc), .d_instruction(d_instruction),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_operand_a(d_operand_a), .d_operand_b(d_operand_b),
    .d_wr_addr(d_wr_addr), .d_ctrl(d_ctrl),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .x_valid(x_valid), .x_pc(x_pc), .x_instruction(x_instruction),
    .x_rs_addr(x_rs_addr), .x_rt_addr(x_rt_addr),
    .x_operand_a(x_operand_a), .x_operand_b(x_operand_b),
    .x_wr_addr(x_wr_addr), .x_ctrl(x_ctrl), .stall_count(stall_count)
  );

  decode_execute_pipe_reg #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .d_valid(d_valid), .d_pc(d_pc), .d_instruction(d_instruction),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_operand_a(d_operand_a), .d_operand_b(d_operand_b),
    .d_wr_addr(d_wr_addr), .d_ctrl(d_ctrl),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .x_valid(s_valid), .x_pc(s_pc), .x_instruction(s_instruction),
    .x_rs_addr(s_rs_addr), .x_rt_addr(s_rt_addr),
    .x_operand_a(s_operand_a), .x_operand_b(s_operand_b),
    .x_wr_addr(s_wr_addr), .x_ctrl(s_ctrl), .stall_count(s_stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    string       nm;
    logic        v;
    logic [11:0] pc;
    logic [31:0] ins;
    logic [4:0]  rs, rt, wr;
    logic [31:0] a, b;
    logic [6:0]  ctrl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  exp_t exp_s;
  int   cyc_count = 0;
  int   tests = 0;
  int   fails = 0;
  event chk_ev;

  always @(posedge clock) cyc_count <= cyc_count + 1;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h (t=%0t)", nm, fld, act, req, $time);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc_count) begin
      e = q.pop_front();
      chk(e.nm, "x_valid",       32'(x_valid),       32'(e.v));
      chk(e.nm, "x_pc",          32'(x_pc),          32'(e.pc));
      chk(e.nm, "x_instruction", x_instruction,      e.ins);
      chk(e.nm, "x_rs_addr",     32'(x_rs_addr),     32'(e.rs));
      chk(e.nm, "x_rt_addr",     32'(x_rt_addr),     32'(e.rt));
      chk(e.nm, "x_operand_a",   x_operand_a,        e.a);
      chk(e.nm, "x_operand_b",   x_operand_b,        e.b);
      chk(e.nm, "x_wr_addr",     32'(x_wr_addr),     32'(e.wr));
      chk(e.nm, "x_ctrl",        32'(x_ctrl),        32'(e.ctrl));
      chk(e.nm, "stall_count",   32'(stall_count),   32'(e.cnt));
      chk(e.nm, "sat_count",     32'(s_stall_count), 32'(e.cnt4));
    end
  endtask

  initial forever begin
    @(negedge clock);
    drain();
  end

  initial forever begin
    @(chk_ev);
    drain();
  end

  task automatic next_edge();
    @(negedge clock);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [11:0] pc, input logic [31:0] ins,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wr, input logic [6:0] ctrl);
    d_valid = v; d_pc = pc; d_instruction = ins; d_rs_addr = rs; d_rt_addr = rt;
    d_operand_a = a; d_operand_b = b; d_wr_addr = wr; d_ctrl = ctrl;
  endtask

  task automatic set_mode(input logic s, input logic f, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd);
    stall = s; flush = f; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic exp_set(input logic v, input logic [11:0] pc, input logic [31:0] ins,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wr, input logic [6:0] ctrl);
    exp_s.v = v; exp_s.pc = pc; exp_s.ins = ins; exp_s.rs = rs; exp_s.rt = rt;
    exp_s.a = a; exp_s.b = b; exp_s.wr = wr; exp_s.ctrl = ctrl;
  endtask

  // dly=1: expectation after the coming edge; dly=0: expectation right now.
  task automatic push(input string nm, input int dly);
    exp_t e;
    e = exp_s;
    e.nm = nm;
    e.cyc = cyc_count + dly;
    e.cnt4 = (exp_s.cnt > 16'd15) ? 4'd15 : exp_s.cnt[3:0];
    q.push_back(e);
  endtask

  initial begin
    exp_s.cnt = 16'd0;

    #2;
    exp_set(0, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 7'h00);
    push("reset_init", 0);
    ->chk_ev;

    // All-ones load, then async reset between edges with all-ones still driven.
    next_edge();
    reset = 1'b0;
    set_mode(0, 0, 0, 5'd0, 32'h0);
    set_d(1, 12'hFFF, 32'hFFFFFFFF, 5'h1F, 5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 7'h7F);
    exp_set(1, 12'hFFF, 32'hFFFFFFFF, 5'h1F, 5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 7'h7F);
    push("load_ones", 1);

    next_edge();
    #1 reset = 1'b1;
    #1;
    exp_set(0, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 7'h00);
    push("async_rst_ones", 0);
    ->chk_ev;

    next_edge();
    reset = 1'b0;
    set_d(1, 12'h123, 32'h8C220004, 5'd1, 5'd2, 32'h11, 32'h22, 5'd2, 7'b1000001);
    exp_set(1, 12'h123, 32'h8C220004, 5'd1, 5'd2, 32'h11, 32'h22, 5'd2, 7'b1000001);
    push("load_first", 1);

    for (int i = 1; i <= 3; i++) begin
      next_edge();
      set_mode(1, 0, 0, 5'd0, 32'h0);
      set_d(1, 12'(12'h200 + i), 32'(32'hA0000000 + i), 5'(i), 5'(i + 10),
            32'(i), 32'(i * 2), 5'(i + 3), 7'h3E);
      exp_s.cnt = 16'(i);
      push("stall_hold", 1);
    end

    next_edge();
    set_mode(1, 1, 0, 5'd0, 32'h0);
    set_d(1, 12'h456, 32'hDEADBEEF, 5'd3, 5'd4, 32'h77, 32'h88, 5'd7, 7'h7F);
    exp_set(0, 12'h456, 32'h0, 5'd3, 5'd4, 32'h0, 32'h0, 5'd0, 7'h00);
    push("flush_over_stall", 1);

    next_edge();
    set_mode(1, 0, 1, 5'd3, 32'h99);
    set_d(1, 12'h457, 32'h12345678, 5'd6, 5'd6, 32'h1, 32'h2, 5'd6, 7'h01);
    exp_s.cnt = 16'd4;
    push("wb_on_bubble", 1);

    next_edge();
    set_mode(0, 0, 0, 5'd0, 32'h0);
    set_d(1, 12'h010, 32'h00A51020, 5'd5, 5'd5, 32'h10, 32'h10, 5'd6, 7'b0000011);
    exp_set(1, 12'h010, 32'h00A51020, 5'd5, 5'd5, 32'h10, 32'h10, 5'd6, 7'b0000011);
    push("load_wb_setup", 1);

    next_edge();
    set_mode(1, 0, 1, 5'd5, 32'hABCD);
    set_d(1, 12'h3FF, 32'h11111111, 5'd7, 5'd8, 32'h1, 32'h2, 5'd9, 7'h7F);
    exp_s.a = 32'hABCD; exp_s.b = 32'hABCD; exp_s.cnt = 16'd5;
    push("wb_capture_both", 1);

    next_edge();
    set_mode(1, 0, 1, 5'd0, 32'h5555);
    exp_s.cnt = 16'd6;
    push("wb_addr_zero", 1);

    next_edge();
    set_mode(1, 0, 1, 5'd6, 32'h6666);
    exp_s.cnt = 16'd7;
    push("wb_no_match", 1);

    next_edge();
    set_mode(0, 0, 1, 5'd5, 32'h7777);
    set_d(1, 12'h014, 32'h00A51022, 5'd5, 5'd5, 32'h20, 32'h30, 5'd6, 7'b0000011);
    exp_set(1, 12'h014, 32'h00A51022, 5'd5, 5'd5, 32'h20, 32'h30, 5'd6, 7'b0000011);
    push("wb_ignored_on_load", 1);

    next_edge();
    set_mode(0, 0, 0, 5'd0, 32'h0);
    set_d(1, 12'h018, 32'h01294820, 5'd0, 5'd9, 32'h40, 32'h50, 5'd9, 7'b0000001);
    exp_set(1, 12'h018, 32'h01294820, 5'd0, 5'd9, 32'h40, 32'h50, 5'd9, 7'b0000001);
    push("load_rs_zero", 1);

    next_edge();
    set_mode(1, 0, 1, 5'd0, 32'hFFFF);
    set_d(1, 12'h0FF, 32'h0, 5'd1, 5'd1, 32'h0, 32'h0, 5'd1, 7'h00);
    exp_s.cnt = 16'd8;
    push("wb_reg0_hardwired", 1);

    next_edge();
    set_mode(1, 0, 1, 5'd9, 32'h1234);
    exp_s.b = 32'h1234; exp_s.cnt = 16'd9;
    push("wb_capture_b_only", 1);

    // Reset pulse while stall stays asserted; the following edge stalls again.
    next_edge();
    set_mode(1, 0, 0, 5'd0, 32'h0);
    #1 reset = 1'b1;
    #1;
    exp_set(0, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 7'h00);
    exp_s.cnt = 16'd0;
    push("async_rst_mid_stall", 0);
    ->chk_ev;
    #1 reset = 1'b0;
    exp_s.cnt = 16'd1;
    push("stall_after_reset", 1);

    next_edge();
    set_mode(0, 0, 0, 5'd0, 32'h0);
    set_d(0, 12'h020, 32'h0, 5'd1, 5'd2, 32'h3, 32'h4, 5'd0, 7'b0100000);
    exp_set(0, 12'h020, 32'h0, 5'd1, 5'd2, 32'h3, 32'h4, 5'd0, 7'b0100000);
    push("invalid_passthru", 1);

    for (int i = 1; i <= 20; i++) begin
      next_edge();
      set_mode(1, 0, 1, 5'd1, 32'hBEEF);
      set_d(1, 12'(12'h300 + i), 32'hCAFE0000, 5'd3, 5'd4, 32'h5, 32'h6, 5'd7, 7'h7F);
      exp_s.cnt = 16'(1 + i);
      push("saturation", 1);
    end

    next_edge();
    set_mode(0, 1, 0, 5'd0, 32'h0);
    set_d(1, 12'h0AB, 32'h8C220004, 5'd10, 5'd11, 32'h9, 32'hA, 5'd12, 7'h41);
    exp_set(0, 12'h0AB, 32'h0, 5'd10, 5'd11, 32'h0, 32'h0, 5'd0, 7'h00);
    push("flush_only", 1);

    next_edge();
    set_mode(0, 0, 0, 5'd0, 32'h0);
    set_d(1, 12'h0AC, 32'h00000020, 5'd1, 5'd2, 32'h100, 32'h200, 5'd3, 7'h01);
    exp_set(1, 12'h0AC, 32'h00000020, 5'd1, 5'd2, 32'h100, 32'h200, 5'd3, 7'h01);
    push("load_after_flush", 1);

    repeat (3) @(negedge clock);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
